// File: rtl/uart8_rx_fifo_pkg.sv
// Shared constants for the UART receive path.
// Holds the receiver word-width and FIFO depth constants so the receiver and
// the receive FIFO are configured from one place. No ports.
package uart8_rx_fifo_pkg;

    // Receiver data word widths.
    localparam int DATA_BITS_7 = 7;
    localparam int DATA_BITS_8 = 8;

    // Receive FIFO depths (must be powers of two, at least 2).
    localparam int FIFO_DEPTH_16 = 16;
    localparam int FIFO_DEPTH_32 = 32;

    // Width of an entry count able to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart8_rx_fifo_ram.sv
// fifo_ram: storage array for the receive FIFO.
// Synchronous write, asynchronous (combinational) read, contents not reset.
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - data stored at raddr (combinational)
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: captures words from a UART receiver into a show-ahead FIFO.
// A word is captured on the rising edge of the receiver's rxDone level, so a
// done level held for several cycles yields one entry. Each entry keeps the
// receiver frame-error flag next to its data.
//
// Handshake: the head entry is offered with doutValid; it is consumed on a
// cycle where doutValid and doutReady are both high. dout/doutErr are only
// meaningful while doutValid is high and must hold until consumed.
//
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   en         - capture enable
//   rxData     - receiver parallel data
//   rxDone     - receiver done level
//   rxErr      - receiver frame error, valid with rxDone
//   dout       - head data word
//   doutErr    - head error flag
//   doutValid  - FIFO not empty
//   doutReady  - consumer takes the head word
//   count      - number of stored entries
//   full/empty - count==DEPTH / count==0 (registered)
//   overflow   - sticky: a word was dropped because the FIFO was full
//   clrOvf     - clears overflow (a coincident drop wins)
module uart8_rx_fifo
    import uart8_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_8,
    parameter int DEPTH     = FIFO_DEPTH_16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [DATA_BITS-1:0]          rxData,
    input  logic                          rxDone,
    input  logic                          rxErr,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          doutErr,
    output logic                          doutValid,
    input  logic                          doutReady,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    input  logic                          clrOvf
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = count_width(DEPTH);
    localparam int ENTRY_W = DATA_BITS + 1;

    logic             rx_done_prev;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push_req;
    logic             push_accept;
    logic             push_drop;
    logic             pop;
    logic [ENTRY_W-1:0] head_entry;

    assign doutValid = ~empty;
    assign pop       = doutValid & doutReady;
    assign push_req  = rxDone & ~rx_done_prev & en;
    // When full, a simultaneous pop frees the slot the push lands in
    // (wr_ptr == rd_ptr); the head is read before the write takes effect.
    assign push_accept = push_req & (~full | pop);
    assign push_drop   = push_req & full & ~pop;

    always_comb begin
        count_next = count;
        if (push_accept && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push_accept && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // Prev starts high so a done level present at reset release is
            // not mistaken for a new rising edge.
            rx_done_prev <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            rx_done_prev <= rxDone;
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (clrOvf) begin
                overflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_ram (
        .clk  (clk),
        .we   (push_accept),
        .waddr(wr_ptr),
        .wdata({rxErr, rxData}),
        .raddr(rd_ptr),
        .rdata(head_entry)
    );

    assign dout    = head_entry[DATA_BITS-1:0];
    assign doutErr = head_entry[DATA_BITS];

endmodule

// File: doc/uart8_rx_fifo.md
UART8_RX_FIFO -- requirements
Module: uart8_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: width of one received data word; matches the receiver's DATA_BITS.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; power of two, at least 2.
REQ-003 Port clk  input  1: single clock, the same clock that drives the receiver.
REQ-004 Port rstn  input  1: reset, synchronous and active-low.
REQ-005 Port en  input  1: capture enable; when low, no new words are accepted.
REQ-006 Port rxData  input  DATA_BITS: receiver parallel output ("out").
REQ-007 Port rxDone  input  1: receiver done level; may stay high for several clk cycles.
REQ-008 Port rxErr  input  1: receiver frame-error flag, valid together with rxDone.
REQ-009 Port dout  output  DATA_BITS: data word at the FIFO head.
REQ-010 Port doutErr  output  1: error flag stored with the head word.
REQ-011 Port doutValid  output  1: head entry is valid (FIFO not empty).
REQ-012 Port doutReady  input  1: consumer accepts the head word.
REQ-013 Port count  output  log2(DEPTH)+1: number of stored entries.
REQ-014 Port full, empty  output  1 each: count==DEPTH and count==0 respectively.
REQ-015 Port overflow  output  1: sticky flag, set when a word is dropped.
REQ-016 Port clrOvf  input  1: clears overflow.

Function
REQ-017 Push event: rxDone==1 and rxDonePrev==0 and en==1, where rxDonePrev is rxDone registered once on clk.
REQ-018 A push writes {rxErr, rxData} at wrPtr; wrPtr increments modulo DEPTH; count increments by 1.
REQ-019 Pop event: doutValid==1 and doutReady==1; rdPtr increments modulo DEPTH; count decrements by 1.
REQ-020 Output is show-ahead: dout and doutErr always reflect the entry at rdPtr; when empty, their value is don't-care.
REQ-021 Latency: after a push edge into an empty FIFO, doutValid is high in the very next cycle, with the pushed word on dout.
REQ-022 A push and a pop in the same cycle, when not full, leave count unchanged and move both pointers.
REQ-023 A push and a pop in the same cycle, when full, accept the push; count stays DEPTH; overflow is not set.
REQ-024 A push when full without a pop discards the word, leaves the pointers unchanged, and sets overflow on the next edge.
REQ-025 A push attempt while empty cannot coincide with a pop, because doutValid is low.
REQ-026 A level rxDone held high for N cycles produces exactly one push.
REQ-027 With en low, a rising rxDone is ignored; stored entries remain readable and poppable.
REQ-028 Raising en while rxDone is already high does not push; rxDonePrev keeps tracking rxDone regardless of en.
REQ-029 clrOvf clears overflow on the next edge; if clrOvf and an overflow drop coincide, overflow is set (set wins).
REQ-030 Pointers are log2(DEPTH) bits and wrap naturally; full and empty derive from count, not from pointer comparison.
REQ-031 full, empty and count are registered state, with no combinational path from rxDone to them.

Reset
REQ-032 With rstn low at a clk edge: wrPtr=0, rdPtr=0, count=0, overflow=0, and rxDonePrev=1.
REQ-033 rxDonePrev resets to 1 so that rxDone high at reset release does not cause a spurious push.
REQ-034 Storage array contents are not reset; reset mid-operation discards all stored entries.
REQ-035 Outputs after reset: empty=1, full=0, doutValid=0, count=0, overflow=0.

Structure
REQ-036 The FIFO depth constants (FIFO_DEPTH_16, FIFO_DEPTH_32) belong in the shared defines include, next to the DATA_BITS constants.
REQ-037 Storage is the sub-module fifo_ram: DEPTH x (DATA_BITS+1) entries, synchronous write, asynchronous read; all control logic stays in uart8_rx_fifo.

Verification
REQ-038 Single word: rxData=0x55, rxDone high for 4 cycles -> exactly one push, count=1, dout=0x55, doutErr=0; doutReady pulse -> empty=1.
REQ-039 Order and error flag: push 0x55 (err=0), then 0x96 (err=1), then pop twice -> 0x55/0 followed by 0x96/1.
REQ-040 Fill and overflow: 16 pushes 0x00..0x0F, then push 0xAA -> full=1, overflow=1, count=16; pops return 0x00..0x0F and 0xAA never appears; clrOvf -> overflow=0.
REQ-041 Full push+pop: 16 entries, push 0xBB together with doutReady -> count stays 16, overflow=0, last popped word is 0xBB.
REQ-042 en and reset: en=0 during a rxDone edge -> count unchanged; rstn low with 3 entries stored -> count=0, empty=1; rxDone held high across reset release -> no push.
REQ-043 Wrap-around: push/pop 40 words 0x00..0x27 in interleaved bursts -> output order is preserved across pointer wrap.
